// File: rtl/exec_controller.sv
// Run/step/halt sequencer for the miniRISC datapath: FETCH/EXEC cycle split, breakpoint,
// halt instruction and saturating debug counters.
module exec_controller #(
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    parameter logic [4:0]  HALT_FUNC   = 5'b11111,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             stop_i,
    input  logic             bkpt_en_i,
    input  logic [31:0]      bkpt_addr_i,
    input  logic [31:0]      instr_addr_i,
    input  logic [5:0]       opcode_i,
    input  logic [4:0]       func_i,
    output logic             pc_en_o,
    output logic             wr_en_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [1:0]       halt_cause_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instr_count_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalted} state_e;

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseStop  = 2'b01;
    localparam logic [1:0] CauseBkpt  = 2'b10;
    localparam logic [1:0] CauseHalt  = 2'b11;

    state_e           state_q;
    logic             run_mode_q;
    logic             stop_pend_q;
    logic             skip_bkpt_q;
    logic [1:0]       halt_cause_q;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             is_halt;
    logic             bkpt_hit;

    always_comb begin
        is_halt  = (opcode_i == HALT_OPCODE) && (func_i == HALT_FUNC);
        bkpt_hit = bkpt_en_i && (instr_addr_i == bkpt_addr_i) && !skip_bkpt_q;
        cycle_d  = (cycle_q == {CNT_W{1'b1}}) ? cycle_q : cycle_q + 1'b1;
        instr_d  = (instr_q == {CNT_W{1'b1}}) ? instr_q : instr_q + 1'b1;
    end

    // Gated by reset so an instruction interrupted by rst never loads the PC.
    assign pc_en_o       = (state_q == StExec) && !is_halt && !rst_i;
    assign wr_en_o       = pc_en_o;
    assign busy_o        = (state_q == StFetch) || (state_q == StExec);
    assign halted_o      = (state_q == StHalted);
    assign halt_cause_o  = halt_cause_q;
    assign cycle_count_o = cycle_q;
    assign instr_count_o = instr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            run_mode_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
            skip_bkpt_q  <= 1'b0;
            halt_cause_q <= CauseNone;
            cycle_q      <= '0;
            instr_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run_i || step_i) begin
                        state_q    <= StFetch;
                        run_mode_q <= run_i;
                    end
                end
                StFetch: begin
                    cycle_q     <= cycle_d;
                    skip_bkpt_q <= 1'b0;
                    if (bkpt_hit) begin
                        state_q      <= StHalted;
                        halt_cause_q <= CauseBkpt;
                        stop_pend_q  <= 1'b0;
                    end else begin
                        state_q     <= StExec;
                        stop_pend_q <= stop_pend_q | stop_i;
                    end
                end
                StExec: begin
                    cycle_q <= cycle_d;
                    if (is_halt) begin
                        state_q      <= StHalted;
                        halt_cause_q <= CauseHalt;
                        stop_pend_q  <= 1'b0;
                    end else begin
                        instr_q <= instr_d;
                        if (run_mode_q && !stop_pend_q && !stop_i) begin
                            state_q <= StFetch;
                        end else begin
                            state_q      <= StHalted;
                            halt_cause_q <= CauseStop;
                            stop_pend_q  <= 1'b0;
                        end
                    end
                end
                StHalted: begin
                    // Halt-instruction stops are sticky; the others resume past the breakpoint.
                    if (halt_cause_q != CauseHalt && (run_i || step_i)) begin
                        state_q      <= StFetch;
                        run_mode_q   <= run_i;
                        skip_bkpt_q  <= 1'b1;
                        halt_cause_q <= CauseNone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: a behavioural PC/program environment plus an instruction-level
// reference model predicting halt cause, commits, cycles and final PC of each session.
module tb_exec_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0, run = 1'b0, step = 1'b0, stop = 1'b0, bkpt_en = 1'b0;
    logic [31:0] bkpt_addr = '0;
    logic [31:0] pc = '0;
    logic [5:0]  opcode;
    logic [4:0]  func;

    logic        pc_en, wr_en, busy, halted;
    logic [1:0]  cause;
    logic [31:0] cyc_cnt, ins_cnt;
    logic        s_pc_en, s_wr_en, s_busy, s_halted;
    logic [1:0]  s_cause;
    logic [1:0]  s_cyc, s_ins;

    exec_controller dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step), .stop_i(stop),
        .bkpt_en_i(bkpt_en), .bkpt_addr_i(bkpt_addr), .instr_addr_i(pc),
        .opcode_i(opcode), .func_i(func), .pc_en_o(pc_en), .wr_en_o(wr_en),
        .busy_o(busy), .halted_o(halted), .halt_cause_o(cause),
        .cycle_count_o(cyc_cnt), .instr_count_o(ins_cnt)
    );

    // Narrow-counter copy driven identically, used to observe saturation.
    exec_controller #(.CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step), .stop_i(stop),
        .bkpt_en_i(bkpt_en), .bkpt_addr_i(bkpt_addr), .instr_addr_i(pc),
        .opcode_i(opcode), .func_i(func), .pc_en_o(s_pc_en), .wr_en_o(s_wr_en),
        .busy_o(s_busy), .halted_o(s_halted), .halt_cause_o(s_cause),
        .cycle_count_o(s_cyc), .instr_count_o(s_ins)
    );

    always #5 clk = ~clk;

    logic [10:0] prog [64];
    assign {opcode, func} = prog[pc[7:2]];

    always @(posedge clk) begin
        if (rst) pc <= '0;
        else if (pc_en) pc <= pc + 32'd4;
    end

    int     n_cmp = 0, n_fail = 0;
    longint tot_instr = 0, tot_cyc = 0;
    bit     resume_skip = 0;
    logic [1:0] last_cause = 2'b00;

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic load_prog(input int halt_pct, input int halt_at);
        logic [10:0] w;
        for (int i = 0; i < 64; i++) begin
            w = 11'($urandom);
            if (w == 11'h7FF) w = 11'h000;
            if (halt_pct > 0 && $urandom_range(99, 0) < halt_pct) w = 11'h7FF;
            prog[i] = w;
        end
        prog[63] = 11'h7FF;
        if (halt_at >= 0) prog[halt_at] = 11'h7FF;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; run = 0; step = 0; stop = 0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        tot_instr = 0; tot_cyc = 0; resume_skip = 0; last_cause = 2'b00;
    endtask

    // Instruction-level model: walk the program from pc0 until something stops execution.
    task automatic model(input logic [31:0] pc0, input bit run_mode, input bit skip,
                         input int stop_at, output logic [1:0] ecause, output int commits,
                         output int cycles, output logic [31:0] pc_end);
        logic [31:0] p;
        bit first;
        p = pc0; first = 1; commits = 0; cycles = 0; ecause = 2'b00;
        for (int g = 0; g < 200; g++) begin
            cycles++;
            if (bkpt_en && p == bkpt_addr && !(first && skip)) begin ecause = 2'b10; break; end
            cycles++;
            if (prog[p[7:2]] == 11'h7FF) begin ecause = 2'b11; break; end
            commits++; p = p + 4; first = 0;
            if (!run_mode || commits == stop_at) begin ecause = 2'b01; break; end
        end
        pc_end = p;
    endtask

    task automatic session(input string name, input bit do_run, input bit do_step,
                           input int stop_at, input bit noise);
        logic [1:0]  ecause;
        logic [31:0] epc;
        int ecom, ecyc, seen;
        bit done;
        model(pc, do_run, resume_skip, stop_at, ecause, ecom, ecyc, epc);
        seen = 0; done = 0;
        @(negedge clk); run = do_run; step = do_step;
        @(negedge clk); run = 0; step = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (halted) begin
                done = 1;
            end else begin
                n_cmp++;
                if (wr_en !== pc_en) begin
                    n_fail++;
                    $display("FAIL %s wr_en: got %b want %b", name, wr_en, pc_en);
                end
                if (pc_en) seen++;
                stop = (stop_at > 0 && pc_en && seen == stop_at);
                if (noise) begin run = 1'($urandom); step = 1'($urandom); end
                @(negedge clk);
            end
        end
        run = 0; step = 0; stop = 0;
        tot_instr += ecom; tot_cyc += ecyc;
        n_cmp++;
        if (!done) begin n_fail++; $display("FAIL %s timeout: got busy want halted", name); end
        n_cmp++;
        if (cause !== ecause) begin
            n_fail++; $display("FAIL %s cause: got %b want %b", name, cause, ecause);
        end
        n_cmp++;
        if (ins_cnt !== 32'(tot_instr)) begin
            n_fail++; $display("FAIL %s instr: got %0d want %0d", name, ins_cnt, tot_instr);
        end
        n_cmp++;
        if (cyc_cnt !== 32'(tot_cyc)) begin
            n_fail++; $display("FAIL %s cycles: got %0d want %0d", name, cyc_cnt, tot_cyc);
        end
        n_cmp++;
        if (pc !== epc) begin
            n_fail++; $display("FAIL %s pc: got %h want %h", name, pc, epc);
        end
        n_cmp++;
        if (seen != ecom) begin
            n_fail++; $display("FAIL %s commits: got %0d want %0d", name, seen, ecom);
        end
        n_cmp++;
        if ({s_ins, s_cyc} !== {2'(sat(tot_instr, 3)), 2'(sat(tot_cyc, 3))}) begin
            n_fail++;
            $display("FAIL %s sat_counters: got %0d/%0d want %0d/%0d", name, s_ins, s_cyc,
                     sat(tot_instr, 3), sat(tot_cyc, 3));
        end
        last_cause  = ecause;
        resume_skip = (ecause == 2'b01 || ecause == 2'b10);
    endtask

    task automatic test_reset();
        load_prog(0, -1);
        do_reset();
        n_cmp++;
        if ({pc_en, wr_en, busy, halted, cause} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {pc_en, wr_en, busy, halted, cause});
        end
        n_cmp++;
        if ({cyc_cnt, ins_cnt, s_cyc, s_ins} !== 68'b0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cyc_cnt, ins_cnt);
        end
    endtask

    task automatic test_step();
        load_prog(0, -1);
        do_reset();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        n_cmp++;
        if ({pc_en, busy} !== 2'b01) begin
            n_fail++; $display("FAIL step_fetch pc_en/busy: got %b want 01", {pc_en, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({pc_en, wr_en, busy} !== 3'b111) begin
            n_fail++; $display("FAIL step_exec pc_en/wr_en/busy: got %b want 111", {pc_en, wr_en, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({halted, cause, ins_cnt, cyc_cnt, pc} !== {1'b1, 2'b01, 32'd1, 32'd2, 32'd4}) begin
            n_fail++;
            $display("FAIL step_done: got halted=%b cause=%b instr=%0d cyc=%0d pc=%h want 1 01 1 2 4",
                     halted, cause, ins_cnt, cyc_cnt, pc);
        end
        tot_instr = 1; tot_cyc = 2; resume_skip = 1; last_cause = 2'b01;
        session("step_resume", 0, 1, 0, 1);
    endtask

    task automatic test_run_stop();
        load_prog(0, -1);
        do_reset();
        session("run_stop", 1, 0, 10, 1);
        n_cmp++;
        if ({ins_cnt, cyc_cnt} !== {32'd10, 32'd20}) begin
            n_fail++; $display("FAIL run_stop_const: got %0d/%0d want 10/20", ins_cnt, cyc_cnt);
        end
    endtask

    task automatic test_breakpoint();
        load_prog(0, -1);
        bkpt_en = 1'b1; bkpt_addr = 32'h10;
        do_reset();
        session("bkpt", 1, 0, 0, 0);
        n_cmp++;
        if ({cause, ins_cnt, pc} !== {2'b10, 32'd4, 32'h10}) begin
            n_fail++;
            $display("FAIL bkpt_const: got cause=%b instr=%0d pc=%h want 10 4 10", cause, ins_cnt, pc);
        end
        session("bkpt_resume", 1, 0, 3, 0);
        n_cmp++;
        if (pc !== 32'h1C) begin
            n_fail++; $display("FAIL bkpt_resume_pc: got %h want 1c", pc);
        end
        bkpt_en = 1'b0;
    endtask

    task automatic test_halt_instr();
        load_prog(0, 2);
        do_reset();
        session("halt", 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run = (i % 2 == 0); step = (i % 3 == 0);
            @(negedge clk);
            n_cmp++;
            if ({halted, cause, pc_en, pc} !== {1'b1, 2'b11, 1'b0, 32'h8}) begin
                n_fail++;
                $display("FAIL halt_sticky: got halted=%b cause=%b pc_en=%b pc=%h want 1 11 0 8",
                         halted, cause, pc_en, pc);
            end
        end
        run = 0; step = 0;
        n_cmp++;
        if ({ins_cnt, cyc_cnt} !== {32'd2, 32'd6}) begin
            n_fail++; $display("FAIL halt_counters: got %0d/%0d want 2/6", ins_cnt, cyc_cnt);
        end
    endtask

    task automatic test_run_step_same();
        load_prog(0, -1);
        do_reset();
        session("run_step", 1, 1, 5, 0);
        n_cmp++;
        if (ins_cnt !== 32'd5) begin
            n_fail++; $display("FAIL run_step_mode: got %0d want 5", ins_cnt);
        end
    endtask

    task automatic test_reset_in_exec();
        load_prog(0, -1);
        do_reset();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1;
        n_cmp++;
        if ({pc_en, wr_en} !== 2'b00) begin
            n_fail++; $display("FAIL rst_exec_gate: got %b want 00", {pc_en, wr_en});
        end
        @(negedge clk); rst = 1'b0;
        n_cmp++;
        if ({busy, halted, cause, ins_cnt, cyc_cnt, pc} !== 100'b0) begin
            n_fail++;
            $display("FAIL rst_exec_state: got busy=%b halted=%b instr=%0d cyc=%0d pc=%h want zeros",
                     busy, halted, ins_cnt, cyc_cnt, pc);
        end
        tot_instr = 0; tot_cyc = 0; resume_skip = 0; last_cause = 2'b00;
    endtask

    task automatic test_saturation();
        load_prog(0, -1);
        do_reset();
        session("sat", 1, 0, 6, 0);
        n_cmp++;
        if ({s_ins, s_cyc} !== 4'b1111) begin
            n_fail++; $display("FAIL sat_hold: got %0d/%0d want 3/3", s_ins, s_cyc);
        end
    endtask

    task automatic test_random();
        bit m;
        for (int it = 0; it < 6; it++) begin
            load_prog(8, -1);
            bkpt_en = 1'($urandom); bkpt_addr = 32'($urandom_range(20, 0)) * 4;
            do_reset();
            for (int s = 0; s < 3; s++) begin
                if (last_cause == 2'b11) break;
                m = 1'($urandom);
                session("random", m, !m || 1'($urandom), $urandom_range(8, 1), 1);
            end
        end
        bkpt_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_stop();
        test_breakpoint();
        test_halt_instr();
        test_run_step_same();
        test_reset_in_exec();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
